// File: rtl/sm_seq_mul.sv
// Sequential sign-magnitude multiplier: shift-add over the magnitudes, one multiplier bit per clock.
// Optional macro SM_SEQ_MUL_EARLY_TERM_EN ends RUN as soon as the remaining multiplier bits are all zero.
module sm_seq_mul #(
    parameter int WIDTH = 4,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [WIDTH-1:0]       a,
    input  logic [WIDTH-1:0]       b,
    output logic                   busy,
    output logic                   done,
    output logic [2*(WIDTH-1):0]   product,
    output logic                   zeroFlag
);

    localparam int M = WIDTH - 1;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(M - 1);

    // Handshake: start is sampled only at an edge where busy=0; done pulses for
    // exactly one cycle, coinciding with the product/zeroFlag update.
    logic [0:0]        state_q,   state_d;
    logic [M-1:0]      mcand_q,   mcand_d;
    logic [M-1:0]      mplier_q,  mplier_d;
    logic [2*M-1:0]    acc_q,     acc_d;
    logic [CNT_W-1:0]  cnt_q,     cnt_d;
    logic              sign_q,    sign_d;
    logic [2*M:0]      product_q, product_d;
    logic              zero_q,    zero_d;
    logic              done_q,    done_d;

    logic [2*M-1:0]    mcand_ext;
    logic [2*M-1:0]    addend;
    logic [2*M-1:0]    acc_next;
    logic [M-1:0]      mplier_sh;
    logic              last_step;

    assign mcand_ext = {{M{1'b0}}, mcand_q};
    assign addend    = mcand_ext << cnt_q;
    assign acc_next  = mplier_q[0] ? (acc_q + addend) : acc_q;
    assign mplier_sh = mplier_q >> 1;

`ifdef SM_SEQ_MUL_EARLY_TERM_EN
    assign last_step = (cnt_q == LAST_CNT) || (mplier_sh == '0);
`else
    assign last_step = (cnt_q == LAST_CNT);
`endif

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        sign_d    = sign_q;
        product_d = product_q;
        zero_d    = zero_q;
        done_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mcand_d  = a[M-1:0];
                    mplier_d = b[M-1:0];
                    sign_d   = a[WIDTH-1] ^ b[WIDTH-1];
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                acc_d    = acc_next;
                mplier_d = mplier_sh;
                cnt_d    = cnt_q + CNT_W'(1);
                if (last_step) begin
                    // Sign is dropped on a zero magnitude so -0 never leaves the block.
                    product_d = {sign_q & (acc_next != '0), acc_next};
                    zero_d    = (acc_next == '0);
                    done_d    = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            sign_q    <= 1'b0;
            product_q <= '0;
            zero_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            sign_q    <= sign_d;
            product_q <= product_d;
            zero_q    <= zero_d;
            done_q    <= done_d;
        end
    end

    assign busy     = (state_q == S_RUN);
    assign done     = done_q;
    assign product  = product_q;
    assign zeroFlag = zero_q;

endmodule

// File: tb/tb_sm_seq_mul.sv
// Self-checking bench for sm_seq_mul: directed cases plus random operations against an arithmetic model.
// Honours SM_SEQ_MUL_EARLY_TERM_EN for the expected latency.
module tb_sm_seq_mul;

    localparam int W = 4;
    localparam int M = W - 1;
    localparam int P = 2 * M + 1;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [P-1:0] product;
    logic         zeroFlag;

    int vectors;
    int miscompares;
    logic [P-1:0] exp_q[$];

    sm_seq_mul #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .product  (product),
        .zeroFlag (zeroFlag)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [P-1:0] model_mul(input logic [W-1:0] x, input logic [W-1:0] y);
        int unsigned mx, my, mag;
        logic neg;
        mx  = int'(x[M-1:0]);
        my  = int'(y[M-1:0]);
        mag = mx * my;
        neg = (x[W-1] != y[W-1]) && (mag != 0);
        return {neg, mag[P-2:0]};
    endfunction

    function automatic int model_latency(input logic [W-1:0] y);
`ifdef SM_SEQ_MUL_EARLY_TERM_EN
        int k;
        k = 1;
        for (int i = 0; i < M; i++) if (y[i]) k = i + 1;
        return k + 1;
`else
        return M + 1;
`endif
    endfunction

    // ---------------- driver tasks ----------------
    // Called at a negedge: holds start over one rising edge, returns at the next negedge.
    task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tbv);
        a = ta;
        b = tbv;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
    endtask

    task automatic wait_done(output logic [P-1:0] prod, output logic zf, output int lat,
                             output int nbusy, output logic busy_at_done, output bit tmo);
        lat = 1;
        nbusy = 0;
        while (done !== 1'b1 && lat < 100) begin
            if (busy === 1'b1) nbusy++;
            @(negedge clk);
            lat++;
        end
        tmo = (done !== 1'b1);
        busy_at_done = busy;
        prod = product;
        zf = zeroFlag;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        start = 1'b1;
        a = W'($urandom);
        b = W'($urandom);
        repeat (2) @(negedge clk);
        vectors++;
        if ({busy, done, product, zeroFlag} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: busy=%b done=%b product=%b zero=%b, need all 0", busy, done, product, zeroFlag);
        end
        rst = 1'b0;
        start = 1'b0;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_idle: busy=%b done=%b, need 0 0", busy, done);
        end
    endtask

    task automatic test_plan_cases();
        logic [W-1:0] ta[3]   = '{4'b0101, 4'b1000, 4'b0110};
        logic [W-1:0] tbv[3]  = '{4'b1011, 4'b0110, 4'b0001};
        logic [P-1:0] tex[3]  = '{7'b1001111, 7'b0000000, 7'b0000110};
        logic [P-1:0] prod;
        logic zf, bad;
        int lat, nbusy;
        bit tmo;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            start_op(ta[i], tbv[i]);
            wait_done(prod, zf, lat, nbusy, bad, tmo);
            vectors++;
            if (tmo) begin
                miscompares++;
                $display("FAIL plan%0d_timeout: no done within 100 cycles", i);
            end
            vectors++;
            if (prod !== tex[i] || zf !== (tex[i][P-2:0] == '0)) begin
                miscompares++;
                $display("FAIL plan%0d_result: product=%b zero=%b, need %b %b", i, prod, zf, tex[i], tex[i][P-2:0] == '0);
            end
            vectors++;
            if (lat != model_latency(tbv[i]) || nbusy != lat - 1 || bad !== 1'b0) begin
                miscompares++;
                $display("FAIL plan%0d_timing: done at %0d busy %0d cycles busy_at_done=%b, need %0d %0d 0",
                         i, lat, nbusy, bad, model_latency(tbv[i]), model_latency(tbv[i]) - 1);
            end
            @(negedge clk);
            vectors++;
            if (done !== 1'b0) begin
                miscompares++;
                $display("FAIL plan%0d_done_width: done=%b one cycle after pulse, need 0", i, done);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [P-1:0] prod;
        logic zf, bad;
        int lat, nbusy;
        bit tmo;
        @(negedge clk);
        start_op(4'b0111, 4'b1111);
        wait_done(prod, zf, lat, nbusy, bad, tmo);
        vectors++;
        if (tmo || prod !== 7'b1110001 || zf !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_first: product=%b zero=%b timeout=%0d, need 1110001 0 0", prod, zf, tmo);
        end
        start_op(4'b0010, 4'b0011);
        wait_done(prod, zf, lat, nbusy, bad, tmo);
        vectors++;
        if (tmo || prod !== 7'b0000110 || zf !== 1'b0 || lat != model_latency(4'b0011)) begin
            miscompares++;
            $display("FAIL b2b_second: product=%b zero=%b done at %0d, need 0000110 0 %0d",
                     prod, zf, lat, model_latency(4'b0011));
        end
    endtask

    task automatic test_ignore_busy();
        logic [P-1:0] prod;
        logic zf, bad;
        int lat, nbusy;
        bit tmo;
        @(negedge clk);
        start_op(4'b0101, 4'b1011);
        start = 1'b1;
        a = 4'b0111;
        b = 4'b0111;
        @(negedge clk);
        start = 1'b0;
        wait_done(prod, zf, lat, nbusy, bad, tmo);
        vectors++;
        if (tmo || prod !== 7'b1001111 || zf !== 1'b0 || lat != model_latency(4'b1011) - 1) begin
            miscompares++;
            $display("FAIL ignore_busy: product=%b zero=%b done at +%0d, need 1001111 0 +%0d",
                     prod, zf, lat + 1, model_latency(4'b1011));
        end
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL ignore_no_relatch: busy=%b done=%b after op, need 0 0", busy, done);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [P-1:0] prod;
        logic zf, bad, seen;
        int lat, nbusy;
        bit tmo;
        @(negedge clk);
        start_op(4'b0101, 4'b1011);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        vectors++;
        if ({busy, done, product, zeroFlag} !== '0) begin
            miscompares++;
            $display("FAIL midrun_reset: busy=%b done=%b product=%b zero=%b, need all 0", busy, done, product, zeroFlag);
        end
        seen = 1'b0;
        repeat (M + 2) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
        end
        vectors++;
        if (seen !== 1'b0) begin
            miscompares++;
            $display("FAIL midrun_no_done: activity=%b after abort, need 0", seen);
        end
        start_op(4'b1011, 4'b0010);
        wait_done(prod, zf, lat, nbusy, bad, tmo);
        vectors++;
        if (tmo || prod !== model_mul(4'b1011, 4'b0010) || zf !== 1'b0) begin
            miscompares++;
            $display("FAIL midrun_fresh: product=%b zero=%b, need %b 0", prod, zf, model_mul(4'b1011, 4'b0010));
        end
    endtask

    task automatic test_random();
        logic [W-1:0] ra, rb;
        logic [P-1:0] prod, expv;
        logic zf, bad;
        int lat, nbusy;
        bit tmo;
        @(negedge clk);
        for (int i = 0; i < 60; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            if (i % 7 == 0) ra[M-1:0] = '0;
            exp_q.push_back(model_mul(ra, rb));
            start_op(ra, rb);
            wait_done(prod, zf, lat, nbusy, bad, tmo);
            expv = exp_q.pop_front();
            vectors++;
            if (tmo || prod !== expv || zf !== (expv[P-2:0] == '0)) begin
                miscompares++;
                $display("FAIL rand%0d_result: a=%b b=%b product=%b zero=%b timeout=%0d, need %b %b",
                         i, ra, rb, prod, zf, tmo, expv, expv[P-2:0] == '0);
            end
            vectors++;
            if (lat != model_latency(rb) || nbusy != lat - 1 || bad !== 1'b0) begin
                miscompares++;
                $display("FAIL rand%0d_timing: b=%b done at %0d busy %0d, need %0d %0d",
                         i, rb, lat, nbusy, model_latency(rb), model_latency(rb) - 1);
            end
            if ($urandom_range(0, 1) == 0) begin
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        vectors = 0;
        miscompares = 0;
        rst = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        test_reset();
        test_plan_cases();
        test_back_to_back();
        test_ignore_busy();
        test_reset_mid_run();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sm_seq_mul.md
Name: sm_seq_mul

Overview:
- Parametrised sequential sign-magnitude multiplier.
- Each operand is WIDTH bits: MSB is the sign, the low WIDTH-1 bits are the magnitude.
- Computes the product with a shift-add datapath, one multiplier bit per clock, behind a start/busy/done handshake.
- Next-generation arithmetic unit in the ALU path: replaces fixed-width combinational multiplication and adds registered outputs, negative-zero suppression and an overflow-free product width.

Parameters:
- WIDTH, 4, operand width including sign bit; M = WIDTH-1 is the magnitude width; legal WIDTH >= 3.
- CNT_W, $clog2(WIDTH), width of the internal bit counter.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when busy=0.
- a  input  WIDTH  multiplicand; a[WIDTH-1] sign, a[M-1:0] magnitude.
- b  input  WIDTH  multiplier; same format as a.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse: product and zeroFlag updated this cycle.
- product  output  2*M+1  sign-magnitude result; bit 2*M is the sign, [2*M-1:0] is the magnitude.
- zeroFlag  output  1  high when the last result magnitude was zero.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high on rst.
- While rst=1 at a rising edge:
  - state=IDLE.
  - busy=0, done=0, product=0, zeroFlag=0.
  - internal accumulator, multiplier shift register and counter cleared.
- rst overrides start and any RUN activity. Reset mid-RUN aborts the operation and done never pulses for it.
- States: IDLE, RUN.
- IDLE:
  - Edge with start=1 accepts the operation: latch |a| into mcand, |b| into mplier, and sign_r = a[WIDTH-1] ^ b[WIDTH-1].
  - Clear acc (2*M bits) and counter; go to RUN.
  - start=0: stay in IDLE; product and zeroFlag hold their last values.
- RUN, one edge per step:
  - If mplier[0]=1: acc <= acc + (mcand << counter), with mcand zero-extended to 2*M bits.
  - mplier <= mplier >> 1; counter <= counter + 1.
  - Last step is counter = M-1 (exactly M RUN cycles).
  - On the last step's edge:
    - product <= {sign_r & (final_acc != 0), final_acc}, where final_acc includes this step's add.
    - zeroFlag <= (final_acc == 0).
    - done <= 1; go to IDLE.
- Negative zero never appears: the sign bit is forced to 0 whenever the magnitude is 0. This includes a sign-only operand (e.g. 1_000).
- Latency: start accepted at edge T; busy=1 during cycles T+1..T+M; done=1 during cycle T+M+1 (M+1 cycles after accept) with busy=0.
- Throughput: start asserted in the done cycle is accepted, giving back-to-back operations every M+1 cycles.
- start while busy=1 is ignored: no relatch and no effect on the current operation. a and b may change freely after the accept edge.
- done is high for exactly one cycle per completed operation and is 0 at all other times.
- Arithmetic cannot overflow: max magnitude (2^M-1)^2 < 2^(2*M).

Optional Feature:
- Macro: SM_SEQ_MUL_EARLY_TERM_EN.
- When defined:
  - A RUN step is also the last step if the shifted mplier (after this step's shift) is 0.
  - RUN always lasts at least 1 cycle and at most M.
  - Latency = k+1 cycles, where k = index of the highest set bit of |b| plus 1 (k=1 if |b|=0).
  - Results are identical to the non-early version.
- When undefined: always exactly M RUN cycles; latency fixed at M+1.

Test Plan:
- WIDTH=4, a=4'b0101 (+5), b=4'b1011 (-3), start pulse -> busy high 3 cycles; done in cycle 4 after accept; product=7'b1001111; zeroFlag=0.
- WIDTH=4, a=4'b1000 (-0), b=4'b0110 -> product=7'b0000000 (sign suppressed), zeroFlag=1, done after 4 cycles.
- WIDTH=4, a=4'b0111, b=4'b1111 -> product=7'b1110001 (-49), zeroFlag=0. Then start held high in the done cycle with a=4'b0010, b=4'b0011 -> accepted; next done 4 cycles later with product=7'b0000110.
- Start accepted with a=+5, b=-3. start re-pulsed during busy with a=4'b0111, b=4'b0111 -> ignored; product=7'b1001111.
- rst asserted in the 2nd RUN cycle -> next edge: busy=0, done=0, product=0, zeroFlag=0; no done pulse follows. A fresh start then completes normally.
- With SM_SEQ_MUL_EARLY_TERM_EN: a=4'b0110, b=4'b0001 -> busy 1 cycle, done 2 cycles after accept, product=7'b0000110. Without the macro -> busy 3 cycles, done at 4, same product.
